// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event controller.
// - Event type codes carried on evt_type.
// - Packed event record stored in the event FIFO: {btn[2:0], typ[1:0], sw[7:0]}.
// - Per-button state encoding and pending-vector slot offsets.
// - make_evt(): turns a pending-vector index plus a switch snapshot into an event record.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS = 2'b01;
  localparam logic [1:0] EVT_RPT   = 2'b10;
  localparam logic [1:0] EVT_REL   = 2'b11;

  localparam int EVT_W = 3 + 2 + 8;

  // Slot of each event kind inside one button's 3-bit group of the pending vector.
  localparam int PEND_PRESS = 0;
  localparam int PEND_RPT   = 1;
  localparam int PEND_REL   = 2;

  typedef struct packed {
    logic [2:0] btn;
    logic [1:0] typ;
    logic [7:0] sw;
  } evt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } btn_st_e;

  // Pending index = btn*3 + slot; slot 0/1/2 maps onto type code 1/2/3.
  function automatic evt_t make_evt(input int unsigned idx, input logic [7:0] sw);
    evt_t e;
    e.btn = 3'(idx / 3);
    e.typ = 2'((idx % 3) + 1);
    e.sw  = sw;
    return e;
  endfunction

endpackage

// File: rtl/btn_event_ctrl_evt_fifo.sv
// evt_fifo: parameterised first-word-fall-through FIFO.
// - clk, rst_n : clock, asynchronous active-low reset
// - push/wdata : write request and data; ignored when full unless popped the same cycle
// - pop        : consume the head; ignored when empty
// - rdata      : head entry, valid whenever valid=1
// - valid      : FIFO not empty
// - full       : FIFO holds DEPTH entries
// - count      : occupancy 0..DEPTH
module evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    do_pop   = pop & (count_q != '0);
    // A pop in the same cycle frees the slot the push needs when full.
    do_push  = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
    // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; no entry is visible until count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: turns debounced button levels into a queue of press/repeat/release events.
// - clk, rst_n   : clock, asynchronous active-low reset
// - clkdiv       : free-running divider; rising edge of clkdiv[TICK_BIT] is the timing tick
// - button_in    : debounced button levels, 1 = pressed
// - SW_in        : debounced switches, snapshotted with every event
// - repeat_en    : enables auto-repeat events
// - evt_valid/evt_ready, evt_btn, evt_type, evt_sw : FWFT event read port
// - evt_count    : FIFO occupancy
// - overflow     : sticky lost-event flag, cleared by ovf_clr
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int NBTN         = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int TICK_BIT     = 20,
  parameter int HOLD_TICKS   = 8,
  parameter int REPEAT_TICKS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     clkdiv,
  input  logic [NBTN-1:0] button_in,
  input  logic [7:0]      SW_in,
  input  logic            repeat_en,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [2:0]      evt_btn,
  output logic [1:0]      evt_type,
  output logic [7:0]      evt_sw,
  output logic [2:0]      evt_count,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int PEND_N  = 3 * NBTN;
  localparam int PW      = $clog2(PEND_N);
  localparam int CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

  // Per-button FSM state.
  btn_st_e         st_q  [NBTN];
  btn_st_e         st_d  [NBTN];
  logic [CW-1:0]   cnt_q [NBTN];
  logic [CW-1:0]   cnt_d [NBTN];
  logic [NBTN-1:0] btn_prev_q;
  logic            tick_prev_q;
  logic            tick;

  // Pending events and their switch snapshots.
  logic [PEND_N-1:0] pend_q, pend_d, pend_set, pend_clr;
  logic [7:0]        sw_q [PEND_N];
  logic [7:0]        sw_d [PEND_N];
  logic              overflow_q, overflow_d, ovf_new;

  // Arbiter / FIFO interface.
  logic          arb_hit;
  logic [PW-1:0] arb_idx;
  logic          fifo_push, fifo_pop, fifo_valid, fifo_full;
  evt_t          fifo_wdata, fifo_head;
  logic [FCW-1:0] fifo_count;

  logic unused_clkdiv;
  assign unused_clkdiv = ^clkdiv;

  assign tick = clkdiv[TICK_BIT] & ~tick_prev_q;

  // Per-button press / repeat / release detection.
  always_comb begin
    pend_set = '0;
    for (int i = 0; i < NBTN; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (button_in[i] && !btn_prev_q[i]) begin
            pend_set[3*i + PEND_PRESS] = 1'b1;
            cnt_d[i] = CW'(HOLD_TICKS);
            st_d[i]  = ST_HELD;
          end
        end
        ST_HELD, ST_RPT: begin
          if (!button_in[i] && btn_prev_q[i]) begin
            pend_set[3*i + PEND_REL] = 1'b1;
            st_d[i] = ST_IDLE;
          end else if (tick && repeat_en) begin
            // The counter reaching zero on this tick fires the repeat and reloads.
            if (cnt_q[i] == CW'(1)) begin
              pend_set[3*i + PEND_RPT] = 1'b1;
              cnt_d[i] = CW'(REPEAT_TICKS);
              st_d[i]  = ST_RPT;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  // Fixed-priority arbiter: the lowest set index wins, which orders press < repeat < release.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    for (int j = PEND_N - 1; j >= 0; j--) begin
      if (pend_q[j]) begin
        arb_hit = 1'b1;
        arb_idx = PW'(j);
      end
    end
    fifo_push  = arb_hit & (~fifo_full | fifo_pop);
    pend_clr   = PEND_N'(fifo_push) << arb_idx;
    fifo_wdata = make_evt(32'(arb_idx), sw_q[arb_idx]);
  end

  // Pending update: a set on a bit that is leaving this cycle is a fresh event, not a collision.
  always_comb begin
    ovf_new = 1'b0;
    for (int j = 0; j < PEND_N; j++) begin
      sw_d[j] = sw_q[j];
      if (pend_set[j]) begin
        if (pend_q[j] && !pend_clr[j]) begin
          // Repeats are idempotent, so a second one merges instead of counting as lost.
          if ((j % 3) != PEND_RPT) ovf_new = 1'b1;
        end else begin
          sw_d[j] = SW_in;
        end
      end
    end
    pend_d     = (pend_q & ~pend_clr) | pend_set;
    overflow_d = ovf_new | (overflow_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBTN; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
      for (int j = 0; j < PEND_N; j++) sw_q[j] <= '0;
      btn_prev_q  <= '0;
      tick_prev_q <= 1'b0;
      pend_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      for (int j = 0; j < PEND_N; j++) sw_q[j] <= sw_d[j];
      btn_prev_q  <= button_in;
      tick_prev_q <= clkdiv[TICK_BIT];
      pend_q      <= pend_d;
      overflow_q  <= overflow_d;
    end
  end

  assign fifo_pop = fifo_valid & evt_ready;

  evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_evt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .valid (fifo_valid),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign evt_valid = fifo_valid;
  assign evt_btn   = fifo_head.btn;
  assign evt_type  = fifo_head.typ;
  assign evt_sw    = fifo_head.sw;
  assign evt_count = 3'(fifo_count);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Self-checking bench for btn_event_ctrl: directed scenarios plus a randomized phase,
// compared every cycle against a queue-based reference model.
module tb_btn_event_ctrl;

  localparam int NBTN   = 5;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 8;
  localparam int REP    = 2;
  localparam int PEND_N = 3 * NBTN;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     clkdiv;
  logic [NBTN-1:0] button_in;
  logic [7:0]      SW_in;
  logic            repeat_en;
  logic            evt_valid;
  logic            evt_ready;
  logic [2:0]      evt_btn;
  logic [1:0]      evt_type;
  logic [7:0]      evt_sw;
  logic [2:0]      evt_count;
  logic            overflow;
  logic            ovf_clr;

  btn_event_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clkdiv    (clkdiv),
    .button_in (button_in),
    .SW_in     (SW_in),
    .repeat_en (repeat_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_btn   (evt_btn),
    .evt_type  (evt_type),
    .evt_sw    (evt_sw),
    .evt_count (evt_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tick_sh = 1;
  int n_rpt_seen = 0;

  // Reference model state.
  bit                m_held [NBTN];
  bit                m_prev [NBTN];
  int                m_eff  [NBTN];
  logic [PEND_N-1:0] m_pend;
  logic [7:0]        m_snap [PEND_N];
  logic [12:0]       m_q [$];
  bit                m_ovf;
  bit                m_tick_prev;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NBTN; i++) begin
      m_held[i] = 0; m_prev[i] = 0; m_eff[i] = 0;
    end
    for (int j = 0; j < PEND_N; j++) m_snap[j] = '0;
    m_pend = '0;
    m_q.delete();
    m_ovf = 0;
    m_tick_prev = 0;
  endtask

  // One clock edge of the specified behaviour, evaluated from pre-edge inputs and state.
  task automatic model_step();
    bit tick, pop, push, ovf_new;
    int hit;
    logic [PEND_N-1:0] set_v, clr_v;
    logic [12:0] ev;
    tick = clkdiv[20] && !m_tick_prev;
    m_tick_prev = clkdiv[20];
    pop = (m_q.size() > 0) && evt_ready;
    hit = -1;
    for (int j = 0; j < PEND_N; j++) if (m_pend[j] && hit < 0) hit = j;
    push = (hit >= 0) && ((m_q.size() < DEPTH) || pop);
    clr_v = '0;
    ev = '0;
    if (push) begin
      clr_v[hit] = 1'b1;
      ev = {3'(hit / 3), 2'(hit % 3 + 1), m_snap[hit]};
    end
    set_v = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (!m_held[i] && button_in[i] && !m_prev[i]) begin
        set_v[i*3] = 1'b1; m_held[i] = 1; m_eff[i] = 0;
      end else if (m_held[i] && !button_in[i]) begin
        set_v[i*3+2] = 1'b1; m_held[i] = 0;
      end else if (m_held[i] && tick && repeat_en) begin
        m_eff[i]++;
        if (m_eff[i] == HOLD || (m_eff[i] > HOLD && (m_eff[i] - HOLD) % REP == 0))
          set_v[i*3+1] = 1'b1;
      end
      m_prev[i] = button_in[i];
    end
    ovf_new = 0;
    for (int j = 0; j < PEND_N; j++) begin
      if (set_v[j]) begin
        if (m_pend[j] && !clr_v[j]) begin
          if (j % 3 != 1) ovf_new = 1;
        end else begin
          m_snap[j] = SW_in;
        end
      end
    end
    m_pend = (m_pend & ~clr_v) | set_v;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(ev);
    m_ovf = ovf_new || (m_ovf && !ovf_clr);
  endtask

  task automatic compare();
    check("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    check("evt_count", 32'(evt_count), 32'(m_q.size()));
    check("overflow",  32'(overflow),  32'(m_ovf));
    if (m_q.size() != 0) begin
      check("evt_btn",  32'(evt_btn),  32'(m_q[0][12:10]));
      check("evt_type", 32'(evt_type), 32'(m_q[0][9:8]));
      check("evt_sw",   32'(evt_sw),   32'(m_q[0][7:0]));
    end
  endtask

  // Caller sets inputs away from the edge; this drives clkdiv, clocks once, then compares.
  task automatic step();
    clkdiv = $urandom;
    clkdiv[20] = 1'((cyc >> tick_sh) & 1);
    if (evt_valid && evt_ready && evt_type == 2'b10) n_rpt_seen++;
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    cyc++;
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    evt_ready = 1'b1;
    while ((m_q.size() != 0 || m_pend != '0) && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) check("drain_timeout", 32'd1, 32'd0);
    step();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; button_in = '0; SW_in = 8'h00; repeat_en = 1'b0;
    evt_ready = 1'b0; ovf_clr = 1'b0; clkdiv = '0;
    model_reset();
    run(2);
    check("rst_valid", 32'(evt_valid), 32'd0);
    check("rst_count", 32'(evt_count), 32'd0);
    check("rst_ovf",   32'(overflow),  32'd0);
    rst_n = 1'b1;
    run(2);

    // Single press with 2-cycle latency and switch snapshot.
    evt_ready = 1'b0; SW_in = 8'hA5; button_in = 5'b00001;
    step();
    check("press_lat1", 32'(evt_valid), 32'd0);
    SW_in = 8'h3C;
    step();
    check("press_lat2", 32'(evt_valid), 32'd1);
    check("press_sw",   32'(evt_sw),    32'hA5);
    step();
    button_in = 5'b00000;
    run(3);
    drain();

    // Hold btn2 for 14 ticks with repeat enabled: repeats on ticks 8,10,12,14.
    repeat_en = 1'b1; evt_ready = 1'b1; n_rpt_seen = 0;
    button_in = 5'b00100; SW_in = 8'h11;
    step();
    guard = 0;
    while (m_eff[2] < 14 && guard < 200) begin step(); guard++; end
    if (guard >= 200) check("hold_timeout", 32'd1, 32'd0);
    button_in = 5'b00000;
    drain();
    check("rpt_count_en", 32'(n_rpt_seen), 32'd4);

    // Same hold with repeat disabled: press and release only.
    repeat_en = 1'b0; n_rpt_seen = 0;
    button_in = 5'b00100;
    run(70);
    button_in = 5'b00000;
    drain();
    check("rpt_count_dis", 32'(n_rpt_seen), 32'd0);

    // Simultaneous presses drain in index order.
    button_in = 5'b10011; SW_in = 8'h5A;
    run(5);
    button_in = 5'b00000;
    drain();

    // Backpressure: 6 events, FIFO saturates at 4, nothing lost.
    evt_ready = 1'b0;
    button_in = 5'b11111;
    run(4);
    button_in = 5'b11110;
    run(6);
    check("bp_count", 32'(evt_count), 32'd4);
    check("bp_ovf",   32'(overflow),  32'd0);
    drain();
    button_in = 5'b00000;
    drain();

    // Overflow: FIFO full, pend_press[3] waiting, btn3 released and re-pressed.
    evt_ready = 1'b0;
    button_in = 5'b00111; run(2);
    button_in = 5'b00110; run(3);
    button_in = 5'b01110; step();
    button_in = 5'b00110; step();
    button_in = 5'b01110; step();
    step();
    check("ovf_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    step();
    check("ovf_clr", 32'(overflow), 32'd0);
    drain();
    button_in = 5'b00000;
    drain();

    // Randomized phase with fast ticks.
    tick_sh = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int b = 0; b < NBTN; b++)
        if ($urandom_range(15) == 0) button_in[b] = ~button_in[b];
      evt_ready = ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) repeat_en = ~repeat_en;
      ovf_clr = ($urandom_range(31) == 0);
      SW_in = 8'($urandom);
      step();
    end
    ovf_clr = 1'b0; repeat_en = 1'b0; button_in = '0;
    drain();
    tick_sh = 1;

    // Asynchronous reset while btn1 is held and events are queued.
    evt_ready = 1'b0; SW_in = 8'hC3;
    button_in = 5'b00010;
    run(4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(evt_valid), 32'd0);
    check("arst_count", 32'(evt_count), 32'd0);
    run(2);
    rst_n = 1'b1;
    step();
    check("arst_lat1", 32'(evt_valid), 32'd0);
    step();
    check("arst_valid2", 32'(evt_valid), 32'd1);
    check("arst_btn",    32'(evt_btn),   32'd1);
    check("arst_type",   32'(evt_type),  32'd1);
    button_in = '0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
